// File: rtl/mac_tx_arb.sv
// mac_tx_arb: round-robin arbiter merging N_SRC AXI-Stream frame sources onto one MAC TX stream,
// aborting frames that stall mid-frame or exceed MAX_BEATS and dropping their remainder.
module mac_tx_arb #(
  parameter int N_SRC     = 2,
  parameter int N_SYMBOLS = 4,
  parameter int W_SYMBOL  = 8,
  parameter int MAX_BEATS = 380
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_clk_en,
  input  logic [N_SRC-1:0]                    s_axis_tvalid,
  input  logic [N_SRC*N_SYMBOLS-1:0]          s_axis_tkeep,
  input  logic [N_SRC*N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]                    s_axis_tlast,
  output logic [N_SRC-1:0]                    s_axis_tready,
  output logic                                m_axis_tvalid,
  output logic [N_SYMBOLS-1:0]                m_axis_tkeep,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]       m_axis_tdata,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [N_SRC-1:0]                    o_grant,
  output logic                                o_err_gap,
  output logic                                o_err_long
);
  localparam int DW = N_SYMBOLS * W_SYMBOL;
  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] q_owner, q_last, nxt_src;
  logic [CW-1:0] q_beat_cnt;
  logic          own_valid, own_last, beat;
  int            best, d;

  assign own_valid = s_axis_tvalid[q_owner];
  assign own_last  = s_axis_tlast[q_owner];

  // Pick the requester with the smallest rotational distance past the last owner.
  always_comb begin
    nxt_src = '0;
    best = N_SRC;
    d = 0;
    for (int i = 0; i < N_SRC; i++) begin
      d = (i + 2 * N_SRC - int'(q_last) - 1) % N_SRC;
      if (s_axis_tvalid[i] && d < best) begin
        best = d;
        nxt_src = SW'(i);
      end
    end
  end

  assign m_axis_tvalid = i_clk_en & (((state == ST_GRANT) & own_valid) | (state == ST_ABORT));
  assign m_axis_tdata  = (state == ST_GRANT) ? s_axis_tdata[q_owner*DW +: DW] : '0;
  assign m_axis_tkeep  = (state == ST_GRANT) ? s_axis_tkeep[q_owner*N_SYMBOLS +: N_SYMBOLS] : '0;
  assign m_axis_tlast  = (state == ST_ABORT) | ((state == ST_GRANT) & own_last);
  assign beat          = m_axis_tvalid & m_axis_tready & i_clk_en;
  assign o_grant       = (state == ST_IDLE) ? '0 : N_SRC'(1) << q_owner;
  assign o_err_gap     = i_clk_en & (state == ST_GRANT) & ~own_valid & (q_beat_cnt != '0);
  assign o_err_long    = beat & (state == ST_GRANT) & ~own_last & (q_beat_cnt == CW'(MAX_BEATS - 2));

  always_comb begin
    s_axis_tready = '0;
    s_axis_tready[q_owner] = (state == ST_GRANT) ? m_axis_tready & i_clk_en : (state == ST_DROP) & i_clk_en;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      q_owner    <= '0;
      q_last     <= SW'(N_SRC - 1);
      q_beat_cnt <= '0;
    end else if (i_clk_en) begin
      case (state)
        ST_IDLE: if (|s_axis_tvalid) begin
          q_owner <= nxt_src;
          state   <= ST_GRANT;
        end
        ST_GRANT: if (beat && own_last) begin
          q_last     <= q_owner;
          q_beat_cnt <= '0;
          state      <= ST_IDLE;
        end else if (beat) begin
          q_beat_cnt <= q_beat_cnt + 1'b1;
          state      <= o_err_long ? ST_ABORT : ST_GRANT;
        end else if (o_err_gap) begin
          state <= ST_ABORT;
        end
        ST_ABORT: if (beat) state <= ST_DROP;
        default: if (own_valid && own_last) begin
          q_last     <= q_owner;
          q_beat_cnt <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_tx_arb.sv
// tb_mac_tx_arb: directed scenarios with random payloads, checked against a frame-level
// round-robin / abort reference model.
module tb_mac_tx_arb;
  localparam int N = 2;
  localparam int MAXB = 8;
  localparam logic [36:0] ABORT = 37'd1;

  typedef struct packed {
    logic [7:0]  gap;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } sbeat_t;

  logic          i_clk = 0, i_reset = 1, i_clk_en = 1, m_axis_tready = 1;
  logic [N-1:0]  s_axis_tvalid = '0, s_axis_tlast = '0, s_axis_tready;
  logic [N*4-1:0]  s_axis_tkeep = '0;
  logic [N*32-1:0] s_axis_tdata = '0;
  logic          m_axis_tvalid, m_axis_tlast, o_err_gap, o_err_long;
  logic [3:0]    m_axis_tkeep;
  logic [31:0]   m_axis_tdata;
  logic [N-1:0]  o_grant;

  mac_tx_arb #(.N_SRC(N), .N_SYMBOLS(4), .W_SYMBOL(8), .MAX_BEATS(MAXB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tkeep(s_axis_tkeep), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tkeep(m_axis_tkeep), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_grant(o_grant), .o_err_gap(o_err_gap), .o_err_long(o_err_long));

  always #5 i_clk = ~i_clk;

  sbeat_t      sq[N][$];
  sbeat_t      mq[N][$];
  logic [36:0] obs[$], expq[$];
  logic [N-1:0] gr_obs[$], gr_exp[$];
  int          tl_cyc[$], gr_cyc[$];
  int          n_assert = 0, n_fail = 0, cyc = 0, n_gap = 0, n_long = 0;
  int          exp_gap = 0, exp_long = 0, req_cyc = -1, m_last = N - 1;
  int          gcnt[N];
  bit          loaded[N];
  bit          en_toggle = 0, rnd_ready = 0;
  logic [N-1:0] acc = '0, prev_grant = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    cyc++;
    acc = s_axis_tvalid & s_axis_tready;
    if (!i_reset) begin
      if (m_axis_tvalid && m_axis_tready && i_clk_en) begin
        obs.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        if (m_axis_tlast) tl_cyc.push_back(cyc);
      end
      if (o_err_gap) n_gap++;
      if (o_err_long) n_long++;
      if (o_grant != '0 && prev_grant == '0) begin
        gr_obs.push_back(o_grant);
        gr_cyc.push_back(cyc);
      end
      if (req_cyc < 0 && s_axis_tvalid != '0) req_cyc = cyc;
      if (!i_clk_en) begin
        check("dis_mvalid", 64'(m_axis_tvalid), 0);
        check("dis_sready", 64'(s_axis_tready), 0);
      end
      check("err_excl", 64'(o_err_gap & o_err_long), 0);
    end
    prev_grant = o_grant;
  end

  // Source and sink drivers: present queued beats, honouring per-beat idle gaps.
  always @(posedge i_clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && sq[i].size() > 0) begin
        void'(sq[i].pop_front());
        loaded[i] = 0;
      end
      if (sq[i].size() == 0) begin
        s_axis_tvalid[i] = 0;
        loaded[i] = 0;
      end else begin
        if (!loaded[i]) begin
          gcnt[i] = int'(sq[i][0].gap);
          loaded[i] = 1;
        end
        if (gcnt[i] > 0) begin
          gcnt[i]--;
          s_axis_tvalid[i] = 0;
        end else begin
          s_axis_tvalid[i] = 1;
          s_axis_tdata[i*32 +: 32] = sq[i][0].d;
          s_axis_tkeep[i*4 +: 4] = sq[i][0].k;
          s_axis_tlast[i] = sq[i][0].l;
        end
      end
    end
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    i_clk_en = en_toggle ? ~i_clk_en : 1'b1;
  end

  task automatic add_frame(input int src, input int n, input int gap_at, input int gap_len, input bit to_model);
    sbeat_t b;
    for (int j = 0; j < n; j++) begin
      b.d = $urandom;
      b.k = 4'($urandom);
      b.l = (j == n - 1);
      b.gap = (j == gap_at) ? 8'(gap_len) : 8'd0;
      sq[src].push_back(b);
      if (to_model) mq[src].push_back(b);
    end
  endtask

  // Frame-level model: round-robin over pending frames, gap/length aborts, drop remainder.
  task automatic model_run();
    sbeat_t b;
    int s, j;
    bit done;
    forever begin
      s = -1;
      for (int k = 1; k <= N; k++)
        if (s < 0 && mq[(m_last + k) % N].size() > 0) s = (m_last + k) % N;
      if (s < 0) break;
      gr_exp.push_back(N'(1) << s);
      j = 0;
      done = 0;
      do begin
        b = mq[s].pop_front();
        if (!done) begin
          if (j > 0 && b.gap > 0) begin
            expq.push_back(ABORT);
            exp_gap++;
            done = 1;
          end else begin
            expq.push_back({b.d, b.k, b.l});
            j++;
            if (!b.l && j == MAXB - 1) begin
              expq.push_back(ABORT);
              exp_long++;
              done = 1;
            end
          end
        end
      end while (!b.l);
      m_last = s;
    end
  endtask

  task automatic clear();
    obs.delete(); expq.delete(); gr_obs.delete(); gr_exp.delete();
    tl_cyc.delete(); gr_cyc.delete();
    n_gap = 0; n_long = 0; exp_gap = 0; exp_long = 0; req_cyc = -1;
  endtask

  task automatic run_check(input string name);
    int t = 0;
    model_run();
    while ((sq[0].size() > 0 || sq[1].size() > 0 || o_grant != '0) && t < 500) begin
      @(negedge i_clk);
      t++;
    end
    check({name, "_timeout"}, 64'(t < 500), 1);
    repeat (3) @(negedge i_clk);
    check({name, "_nbeats"}, 64'(obs.size()), 64'(expq.size()));
    for (int i = 0; i < obs.size() && i < expq.size(); i++)
      check($sformatf("%s_beat%0d", name, i), 64'(obs[i]), 64'(expq[i]));
    check({name, "_ngrants"}, 64'(gr_obs.size()), 64'(gr_exp.size()));
    for (int i = 0; i < gr_obs.size() && i < gr_exp.size(); i++)
      check($sformatf("%s_grant%0d", name, i), 64'(gr_obs[i]), 64'(gr_exp[i]));
    check({name, "_err_gap"}, 64'(n_gap), 64'(exp_gap));
    check({name, "_err_long"}, 64'(n_long), 64'(exp_long));
  endtask

  initial begin
    int t;
    repeat (2) @(negedge i_clk);
    check("rst_grant", 64'(o_grant), 0);
    check("rst_mvalid", 64'(m_axis_tvalid), 0);
    check("rst_sready", 64'(s_axis_tready), 0);
    check("rst_errs", 64'({o_err_gap, o_err_long}), 0);
    @(posedge i_clk); #2 i_reset = 0;
    clear();

    add_frame(0, 3, -1, 0, 1);
    add_frame(1, 3, -1, 0, 1);
    run_check("both");
    check("grant_latency", 64'(gr_cyc[0] - req_cyc), 1);
    check("idle_between", 64'(gr_cyc[1] - tl_cyc[0]), 2);
    clear();

    for (int f = 0; f < 3; f++) add_frame(1, $urandom_range(1, 5), -1, 0, 1);
    run_check("s1_stream");
    clear();

    rnd_ready = 1;
    add_frame(1, $urandom_range(1, 6), -1, 0, 1);
    add_frame(1, $urandom_range(1, 6), -1, 0, 1);
    add_frame(0, $urandom_range(1, 6), -1, 0, 1);
    run_check("rr_rand_ready");
    rnd_ready = 0;
    clear();

    add_frame(0, 5, 2, 3, 1);
    run_check("gap");
    clear();

    add_frame(1, 12, -1, 0, 1);
    run_check("long");
    clear();

    en_toggle = 1;
    add_frame(0, 4, -1, 0, 1);
    add_frame(1, 3, -1, 0, 1);
    run_check("clk_en");
    en_toggle = 0;
    clear();

    add_frame(0, 2, -1, 0, 1);
    run_check("pre_reset");
    clear();
    add_frame(0, 6, -1, 0, 0);
    t = 0;
    while (obs.size() < 2 && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    check("midframe_timeout", 64'(t < 100), 1);
    @(posedge i_clk); #2 i_reset = 1;
    #1;
    check("async_grant", 64'(o_grant), 0);
    check("async_mvalid", 64'(m_axis_tvalid), 0);
    check("async_sready", 64'(s_axis_tready), 0);
    sq[0].delete();
    sq[1].delete();
    repeat (2) @(posedge i_clk);
    #2 i_reset = 0;
    m_last = N - 1;
    clear();
    add_frame(1, 2, -1, 0, 1);
    add_frame(0, 2, -1, 0, 1);
    run_check("post_reset");
    clear();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
